// File: rtl/led_cnt_multi.sv
// led_cnt_multi: multi-channel, run-time programmable LED blink/PWM/one-shot driver.
//
// Every channel owns a period counter whose limit comes from a constant table indexed
// by its divider (no run-time divide), an 8-bit PWM counter, and its own div/mode/duty
// registers loaded by a one-cycle write strobe.
//
// Ports:
//   clk100  in   1         fabric clock, rising edge
//   rst     in   1         asynchronous active-high reset
//   sync_i  in   1         (only with LED_CNT_MULTI_SYNC_EN) phase-align all running channels
//   wren_i  in   NUM_CH    per-channel config load strobe
//   div_i   in   5*NUM_CH  channel n divider in [5n+4:5n]
//   mode_i  in   2*NUM_CH  channel n mode: 0 off, 1 blink, 2 pwm, 3 one-shot
//   duty_i  in   8*NUM_CH  channel n PWM duty
//   led_o   out  NUM_CH    LED drive, registered
//   tick_o  out  NUM_CH    one-cycle pulse on each period wrap, registered
//
// Optional feature macro: LED_CNT_MULTI_SYNC_EN adds sync_i.

module led_cnt_multi #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned DIV_MAX  = 20,
    parameter int unsigned RST_DIV  = 1,
    parameter int unsigned RST_MODE = 1
) (
    input  logic                  clk100,
    input  logic                  rst,
`ifdef LED_CNT_MULTI_SYNC_EN
    input  logic                  sync_i,
`endif
    input  logic [NUM_CH-1:0]     wren_i,
    input  logic [5*NUM_CH-1:0]   div_i,
    input  logic [2*NUM_CH-1:0]   mode_i,
    input  logic [8*NUM_CH-1:0]   duty_i,
    output logic [NUM_CH-1:0]     led_o,
    output logic [NUM_CH-1:0]     tick_o
);

    localparam int unsigned CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [1:0] {
        ModeOff   = 2'd0,
        ModeBlink = 2'd1,
        ModePwm   = 2'd2,
        ModeShot  = 2'd3
    } mode_e;

    // Period limit (half-period minus one) for every 5-bit divider code.
    function automatic logic [32*CW-1:0] build_limit_tbl();
        logic [32*CW-1:0] tbl;
        int unsigned      q;
        tbl = '0;
        for (int unsigned d = 0; d < 32; d++) begin
            if (d == 0 || d > DIV_MAX) begin
                q = CLK_HZ;
            end else begin
                q = CLK_HZ / d;
            end
            // A divider larger than CLK_HZ would give a zero-length period; clamp to 1.
            if (q == 0) begin
                q = 1;
            end
            tbl[d*CW +: CW] = CW'(q - 1);
        end
        return tbl;
    endfunction

    localparam logic [32*CW-1:0] LIMIT_TBL = build_limit_tbl();

    logic w_sync;
`ifdef LED_CNT_MULTI_SYNC_EN
    assign w_sync = sync_i;
`else
    assign w_sync = 1'b0;
`endif

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [CW-1:0] r_cnt;
        logic [7:0]    r_pwm;
        logic          r_led;
        logic          r_tick;
        logic          r_armed;
        logic [4:0]    r_div;
        mode_e         r_mode;
        logic [7:0]    r_duty;

        logic [CW-1:0] w_cnt_nxt;
        logic [7:0]    w_pwm_nxt;
        logic          w_led_nxt;
        logic          w_tick_nxt;
        logic          w_armed_nxt;
        logic [4:0]    w_div_nxt;
        mode_e         w_mode_nxt;
        logic [7:0]    w_duty_nxt;
        logic [CW-1:0] w_max;
        logic          w_wrap;

        assign w_max  = LIMIT_TBL[32'(r_div) * CW +: CW];
        assign w_wrap = (r_cnt == w_max);

        always_comb begin
            w_cnt_nxt   = r_cnt;
            w_pwm_nxt   = r_pwm;
            w_led_nxt   = r_led;
            w_tick_nxt  = 1'b0;
            w_armed_nxt = r_armed;
            w_div_nxt   = r_div;
            w_mode_nxt  = r_mode;
            w_duty_nxt  = r_duty;

            if (wren_i[n]) begin
                // A write restarts the channel; it never counts as a wrap.
                w_div_nxt   = div_i[5*n +: 5];
                w_mode_nxt  = mode_e'(mode_i[2*n +: 2]);
                w_duty_nxt  = duty_i[8*n +: 8];
                w_cnt_nxt   = '0;
                w_pwm_nxt   = '0;
                w_armed_nxt = (w_mode_nxt == ModeShot);
                unique case (w_mode_nxt)
                    ModeOff:   w_led_nxt = 1'b0;
                    ModeBlink: w_led_nxt = 1'b1;
                    ModePwm:   w_led_nxt = (w_duty_nxt != 8'd0);
                    ModeShot:  w_led_nxt = 1'b1;
                endcase
            end else if (w_sync && r_mode != ModeOff) begin
                w_cnt_nxt = '0;
                w_pwm_nxt = '0;
                if (r_mode == ModeBlink) begin
                    w_led_nxt = 1'b1;
                end else if (r_mode == ModePwm) begin
                    w_led_nxt = (r_duty != 8'd0);
                end
            end else begin
                unique case (r_mode)
                    ModeOff: begin
                        w_cnt_nxt = '0;
                        w_pwm_nxt = '0;
                        w_led_nxt = 1'b0;
                    end
                    ModeBlink: begin
                        if (w_wrap) begin
                            w_cnt_nxt  = '0;
                            w_tick_nxt = 1'b1;
                            w_led_nxt  = ~r_led;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                    ModePwm: begin
                        if (w_wrap) begin
                            w_cnt_nxt  = '0;
                            w_tick_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                        w_pwm_nxt = r_pwm + 8'd1;
                        w_led_nxt = (w_pwm_nxt < r_duty);
                    end
                    ModeShot: begin
                        if (r_armed) begin
                            if (w_wrap) begin
                                w_cnt_nxt   = '0;
                                w_tick_nxt  = 1'b1;
                                w_led_nxt   = 1'b0;
                                w_armed_nxt = 1'b0;
                            end else begin
                                w_cnt_nxt = r_cnt + CW'(1);
                            end
                        end else begin
                            // Spent pulse: hold until the next write re-triggers it.
                            w_cnt_nxt = '0;
                            w_led_nxt = 1'b0;
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge clk100 or posedge rst) begin
            if (rst) begin
                r_cnt   <= '0;
                r_pwm   <= '0;
                r_led   <= 1'b0;
                r_tick  <= 1'b0;
                r_armed <= 1'b0;
                r_div   <= RST_DIV[4:0];
                r_mode  <= mode_e'(RST_MODE[1:0]);
                r_duty  <= '0;
            end else begin
                r_cnt   <= w_cnt_nxt;
                r_pwm   <= w_pwm_nxt;
                r_led   <= w_led_nxt;
                r_tick  <= w_tick_nxt;
                r_armed <= w_armed_nxt;
                r_div   <= w_div_nxt;
                r_mode  <= w_mode_nxt;
                r_duty  <= w_duty_nxt;
            end
        end

        assign led_o[n]  = r_led;
        assign tick_o[n] = r_tick;
    end

endmodule
